// File: rtl/tile_fetch_agu_pkg.sv
// Shared widths, FSM encodings and state type for the tile fetch address generator.
// The optional FETCH_ROW_PITCH_EN build adds a row_pitch port to the top.
`ifndef WORD_ADDR_BITS
`define WORD_ADDR_BITS 16
`endif
`ifndef DATA_MAX_BITS
`define DATA_MAX_BITS 8
`endif
`ifndef FETCH_IDLE
`define FETCH_IDLE 2'd0
`endif
`ifndef FETCH_RUN
`define FETCH_RUN 2'd1
`endif
`ifndef FETCH_DONE
`define FETCH_DONE 2'd2
`endif

package tile_fetch_agu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `FETCH_IDLE,
    ST_RUN  = `FETCH_RUN,
    ST_DONE = `FETCH_DONE
  } fetch_state_t;

  localparam int FETCH_STATE_W = 2;

endpackage

// File: rtl/tile_fetch_agu_dim_counter.sv
// Wrap counter for one tile dimension; idx returns to 0 after reaching size-1.
module fetch_dim_counter
  import tile_fetch_agu_pkg::*;
#(
  parameter int DIM_W = `DATA_MAX_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [DIM_W-1:0] size,
  output logic [DIM_W-1:0] idx,
  output logic             last
);

  assign last = (idx == size - DIM_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + DIM_W'(1);
    end
  end

endmodule

// File: rtl/tile_fetch_agu.sv
// Channel x row x column read-address walker for the operand fetch path.
// Define FETCH_ROW_PITCH_EN to add a row_pitch port for strided sub-tiles.
//
// state   | meaning
// IDLE    | waiting for start; config inputs sampled on start
// RUN     | presenting one address per handshake
// DONE    | one-cycle done pulse, then back to IDLE
module tile_fetch_agu
  import tile_fetch_agu_pkg::*;
#(
  parameter int ADDR_W = `WORD_ADDR_BITS,
  parameter int DIM_W  = `DATA_MAX_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [DIM_W-1:0]  channels,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
`ifdef FETCH_ROW_PITCH_EN
  input  logic [ADDR_W-1:0] row_pitch,
`endif
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wen,
  output logic [DIM_W-1:0]  channel_index,
  output logic [DIM_W-1:0]  row_index,
  output logic [DIM_W-1:0]  col_index,
  output logic              busy,
  output logic              done
);

  fetch_state_t state, state_nxt;

  logic [DIM_W-1:0]  ch_sz, row_sz, col_sz;
  logic [ADDR_W-1:0] row_step, row_base, row_step_in, next_row_base;
  logic accept, hs, zero_dim;
  logic col_last, row_last, ch_last;
  logic row_inc, ch_inc, final_hs;

  assign wen = 1'b0;

`ifdef FETCH_ROW_PITCH_EN
  assign row_step_in = row_pitch;
`else
  assign row_step_in = ADDR_W'(cols);
`endif

  assign accept   = (state == ST_IDLE) && start && !abort;
  assign zero_dim = (channels == '0) || (rows == '0) || (cols == '0);
  assign hs       = addr_valid && addr_ready;
  assign row_inc  = hs && col_last;
  assign ch_inc   = row_inc && row_last;
  assign final_hs = ch_inc && ch_last;
  assign next_row_base = row_base + row_step;

  fetch_dim_counter #(.DIM_W(DIM_W)) u_col (
    .clk(clk), .rst(rst), .clr(accept), .inc(hs),
    .size(col_sz), .idx(col_index), .last(col_last)
  );

  fetch_dim_counter #(.DIM_W(DIM_W)) u_row (
    .clk(clk), .rst(rst), .clr(accept), .inc(row_inc),
    .size(row_sz), .idx(row_index), .last(row_last)
  );

  fetch_dim_counter #(.DIM_W(DIM_W)) u_ch (
    .clk(clk), .rst(rst), .clr(accept), .inc(ch_inc),
    .size(ch_sz), .idx(channel_index), .last(ch_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = zero_dim ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (abort)         state_nxt = ST_IDLE;
        else if (final_hs) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so none of them is a decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      addr_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      addr_valid <= (state_nxt == ST_RUN);
      busy       <= (state_nxt == ST_RUN);
      done       <= (state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_sz    <= '0;
      row_sz   <= '0;
      col_sz   <= '0;
      row_step <= '0;
      row_base <= '0;
      addr_out <= '0;
    end else if (accept) begin
      ch_sz    <= channels;
      row_sz   <= rows;
      col_sz   <= cols;
      row_step <= row_step_in;
      row_base <= src_addr;
      addr_out <= src_addr;
    end else if (hs) begin
      // Row base keeps stepping across channel boundaries; the tile is one flat walk.
      if (col_last) begin
        row_base <= next_row_base;
        addr_out <= next_row_base;
      end else begin
        addr_out <= addr_out + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tile_fetch_agu.sv
// Scoreboard bench for tile_fetch_agu: a 16-bit instance for the walks and an 8-bit one for address wrap.
module tb_tile_fetch_agu;

  localparam int AW = 16;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, addr_ready;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] channels, rows, cols;
  logic          addr_valid, wen, busy, done;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] channel_index, row_index, col_index;

  logic          w_start, w_abort, w_ready;
  logic [7:0]    w_src, w_addr;
  logic [DW-1:0] w_ch, w_rows, w_cols, w_ci, w_ri, w_coi;
  logic          w_valid, w_wen, w_busy, w_done;

`ifdef FETCH_ROW_PITCH_EN
  logic [AW-1:0] row_pitch;
  logic [7:0]    w_pitch;
`endif

  tile_fetch_agu #(.ADDR_W(AW), .DIM_W(DW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_addr(src_addr), .channels(channels), .rows(rows), .cols(cols),
`ifdef FETCH_ROW_PITCH_EN
    .row_pitch(row_pitch),
`endif
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_out(addr_out), .wen(wen),
    .channel_index(channel_index), .row_index(row_index), .col_index(col_index),
    .busy(busy), .done(done)
  );

  tile_fetch_agu #(.ADDR_W(8), .DIM_W(DW)) u_wrap (
    .clk(clk), .rst(rst), .start(w_start), .abort(w_abort),
    .src_addr(w_src), .channels(w_ch), .rows(w_rows), .cols(w_cols),
`ifdef FETCH_ROW_PITCH_EN
    .row_pitch(w_pitch),
`endif
    .addr_valid(w_valid), .addr_ready(w_ready), .addr_out(w_addr), .wen(w_wen),
    .channel_index(w_ci), .row_index(w_ri), .col_index(w_coi),
    .busy(w_busy), .done(w_done)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] ch;
    logic [DW-1:0] row;
    logic [DW-1:0] col;
  } exp_t;

  exp_t q[$];
  exp_t wq[$];
  int total = 0;
  int bad = 0;
  int rdy_mode = 0;
  int rk = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_walk(input logic [AW-1:0] src, input int nc, input int nr,
                           input int ncol, input logic [AW-1:0] step);
    logic [AW-1:0] base;
    exp_t e;
    base = src;
    for (int c = 0; c < nc; c++)
      for (int r = 0; r < nr; r++) begin
        for (int k = 0; k < ncol; k++) begin
          e.addr = base + AW'(k);
          e.ch   = DW'(c);
          e.row  = DW'(r);
          e.col  = DW'(k);
          q.push_back(e);
        end
        base = base + step;
      end
  endtask

  // Pulses start for one cycle; returns just after the edge that sampled it.
  task automatic do_start(input logic [AW-1:0] src, input int nc, input int nr,
                          input int ncol, input logic [AW-1:0] pitch);
    @(posedge clk);
    #1;
    src_addr = src;
    channels = DW'(nc);
    rows     = DW'(nr);
    cols     = DW'(ncol);
`ifdef FETCH_ROW_PITCH_EN
    row_pitch = pitch;
    push_walk(src, nc, nr, ncol, pitch);
`else
    push_walk(src, nc, nr, ncol, AW'(ncol));
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc, input int limit);
    int  cyc;
    logic seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    if (exp_cyc > 0) chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_drained"}, q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rk++;
      if (rdy_mode == 0) addr_ready = 1'b1;
      else if (rdy_mode == 1) addr_ready = (rk % 3 == 0);
    end
  end

  // The head of the queue must be presented every valid cycle; it is consumed only on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst && addr_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", addr_valid, 1'b0);
      end else begin
        e = q[0];
        chk("addr", addr_out, e.addr);
        chk("channel_index", channel_index, e.ch);
        chk("row_index", row_index, e.row);
        chk("col_index", col_index, e.col);
        chk("busy_in_run", busy, 1'b1);
        if (addr_ready) e = q.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && w_valid) begin
      if (wq.size() == 0) begin
        chk("wrap_unexpected_valid", w_valid, 1'b0);
      end else begin
        e = wq[0];
        chk("wrap_addr", w_addr, e.addr);
        chk("wrap_col_index", w_coi, e.col);
        if (w_ready) e = wq.pop_front();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   cyc;
    logic seen;
    logic [7:0] wb;

    rst = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b1;
    src_addr = '0; channels = '0; rows = '0; cols = '0;
    w_start = 1'b0; w_abort = 1'b0; w_ready = 1'b1; w_src = '0;
    w_ch = '0; w_rows = '0; w_cols = '0;
`ifdef FETCH_ROW_PITCH_EN
    row_pitch = '0;
    w_pitch = 8'd4;
`endif

    #12;
    chk("rst_valid", addr_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", addr_out, 0);
    chk("rst_ch", channel_index, 0);
    chk("rst_row", row_index, 0);
    chk("rst_col", col_index, 0);
    chk("rst_wen", wen, 1'b0);
    chk("rst_wrap_valid", w_valid, 1'b0);
    chk("rst_wrap_wen", w_wen, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    do_start(16'h0010, 2, 2, 3, 16'd3);
    wait_done("dense", 13, 100);

`ifdef FETCH_ROW_PITCH_EN
    do_start(16'h0100, 1, 3, 2, 16'd8);
    wait_done("pitch", 7, 50);
`endif

    rdy_mode = 1;
    do_start(16'h0010, 2, 2, 3, 16'd3);
    wait_done("backpressure", 0, 200);
    rdy_mode = 0;

    // Zero-size tile, with a second start landing in the DONE cycle.
    do_start(16'h0020, 1, 0, 4, 16'd4);
    rows  = 8'd2;
    start = 1'b1;
    @(negedge clk);
    chk("zero_done_t1", done, 1'b1);
    chk("zero_valid_t1", addr_valid, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_after_valid", addr_valid, 1'b0);
      chk("zero_after_done", done, 1'b0);
    end

    do_start(16'h0040, 2, 2, 3, 16'd3);
    repeat (5) @(posedge clk);
    #1;
    rdy_mode = 2;
    addr_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    q.delete();
    rdy_mode = 0;
    addr_ready = 1'b1;
    @(negedge clk);
    chk("abort_valid", addr_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
    end
    do_start(16'h0040, 2, 2, 3, 16'd3);
    wait_done("restart", 13, 100);

    do_start(16'h0010, 2, 2, 3, 16'd3);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", addr_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_addr", addr_out, 0);
    chk("arst_ch", channel_index, 0);
    chk("arst_row", row_index, 0);
    chk("arst_col", col_index, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("arst_stays_idle", addr_valid, 1'b0);

    // 8-bit instance: 0xFE, 0xFF, 0x00, 0x01.
    wb = 8'hFE;
    for (int k = 0; k < 4; k++) begin
      e = '0;
      e.addr = AW'(wb);
      e.col  = DW'(k);
      wq.push_back(e);
      wb = wb + 8'd1;
    end
    @(posedge clk);
    #1;
    w_src = 8'hFE; w_ch = 8'd1; w_rows = 8'd1; w_cols = 8'd4;
    w_start = 1'b1;
    @(posedge clk);
    #1;
    w_start = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (w_done) seen = 1'b1;
    end
    chk("wrap_done_seen", seen, 1'b1);
    chk("wrap_done_cycle", cyc, 5);
    chk("wrap_busy_at_done", w_busy, 1'b0);
    chk("wrap_drained", wq.size(), 0);

    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
